// File: rtl/hwag_pkg.sv
// rtl/hwag_pkg.sv - shared types and constants for the hwag coil guard.
package hwag_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHARGE   = 2'd1,
        HOLD     = 2'd2,
        WAIT_LOW = 2'd3
    } coil_guard_state_t;

    localparam int HWAG_COIL_CH = 2;

endpackage

// File: rtl/hwag_coil_guard_ch.sv
// rtl/hwag_coil_guard_ch.sv - one coil channel: dwell limit, minimum off time, spark pulse, sticky overdwell fault.
module hwag_coil_guard_ch
    import hwag_pkg::*;
#(
    parameter int CNT_WIDTH = 24
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 coil_req,
    input  logic [CNT_WIDTH-1:0] max_dwell,
    input  logic [CNT_WIDTH-1:0] min_off,
    input  logic                 fault_clr,
    output logic                 coil_out,
    output logic                 spark,
    output logic                 fault_dwell
);

    coil_guard_state_t    state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] hold_thr;
    logic                 timeout;
    logic                 fault_set;

    // Limits are read live every cycle; min_off of 0 behaves like 1.
    always_comb begin
        cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
        hold_thr  = (min_off == '0) ? '0 : min_off - 1'b1;
        timeout   = (max_dwell != '0) && (cnt == max_dwell - 1'b1);
        fault_set = ena && (state == CHARGE) && coil_req && timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            coil_out    <= 1'b0;
            spark       <= 1'b0;
            fault_dwell <= 1'b0;
        end else begin
            spark <= 1'b0;

            if (fault_set) begin
                fault_dwell <= 1'b1;
            end else if (fault_clr) begin
                fault_dwell <= 1'b0;
            end

            if (!ena) begin
                state    <= IDLE;
                cnt      <= '0;
                coil_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (coil_req) begin
                            state    <= CHARGE;
                            cnt      <= '0;
                            coil_out <= 1'b1;
                        end
                    end
                    CHARGE: begin
                        // A release coinciding with the timeout is a normal release.
                        if (!coil_req) begin
                            state    <= HOLD;
                            cnt      <= '0;
                            coil_out <= 1'b0;
                            spark    <= 1'b1;
                        end else if (timeout) begin
                            state    <= WAIT_LOW;
                            cnt      <= '0;
                            coil_out <= 1'b0;
                            spark    <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    HOLD: begin
                        if (cnt >= hold_thr) begin
                            state <= coil_req ? WAIT_LOW : IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    WAIT_LOW: begin
                        if (!coil_req) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        cnt      <= '0;
                        coil_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/hwag_coil_guard.sv
// rtl/hwag_coil_guard.sv - coil guard top; optional spark statistics under HWAG_COIL_GUARD_STATS_EN.
module hwag_coil_guard
    import hwag_pkg::*;
#(
    parameter int CH_NUM    = HWAG_COIL_CH,
    parameter int CNT_WIDTH = 24
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [CH_NUM-1:0]    coil_req,
    input  logic [CNT_WIDTH-1:0] max_dwell,
    input  logic [CNT_WIDTH-1:0] min_off,
    input  logic                 fault_clr,
    output logic [CH_NUM-1:0]    coil_out,
    output logic [CH_NUM-1:0]    spark,
    output logic [CH_NUM-1:0]    fault_dwell
`ifdef HWAG_COIL_GUARD_STATS_EN
    ,
    output logic [16*CH_NUM-1:0] spark_cnt
`endif
);

    genvar i;

    generate
        for (i = 0; i < CH_NUM; i++) begin : g_ch
            hwag_coil_guard_ch #(
                .CNT_WIDTH (CNT_WIDTH)
            ) u_ch (
                .clk         (clk),
                .rst         (rst),
                .ena         (ena),
                .coil_req    (coil_req[i]),
                .max_dwell   (max_dwell),
                .min_off     (min_off),
                .fault_clr   (fault_clr),
                .coil_out    (coil_out[i]),
                .spark       (spark[i]),
                .fault_dwell (fault_dwell[i])
            );
        end
    endgenerate

`ifdef HWAG_COIL_GUARD_STATS_EN
    // Counts the registered spark pulses, so each count lands one cycle after its pulse.
    generate
        for (i = 0; i < CH_NUM; i++) begin : g_stat
            logic [15:0] cnt_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else if (spark[i]) begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end

            assign spark_cnt[16*i +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_hwag_coil_guard.sv
// tb/tb_hwag_coil_guard.sv - directed and randomized checks of hwag_coil_guard against a timing model.
module tb_hwag_coil_guard;

    localparam int CH = 2;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [CH-1:0] coil_req;
    logic [CW-1:0] max_dwell;
    logic [CW-1:0] min_off;
    logic          fault_clr;
    logic [CH-1:0] coil_out;
    logic [CH-1:0] spark;
    logic [CH-1:0] fault_dwell;
`ifdef HWAG_COIL_GUARD_STATS_EN
    logic [16*CH-1:0] spark_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per channel, time coil has been charged, time spent in forced off, waiting-for-low flag.
    bit m_chg  [CH];
    int m_len  [CH];
    bit m_hold [CH];
    int m_h    [CH];
    bit m_wait [CH];
    bit m_spark[CH];
    bit m_fault[CH];
    int m_stat [CH];

    int hi0;
    int sp0;

    always #5 clk = ~clk;

    hwag_coil_guard #(
        .CH_NUM    (CH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .coil_req    (coil_req),
        .max_dwell   (max_dwell),
        .min_off     (min_off),
        .fault_clr   (fault_clr),
        .coil_out    (coil_out),
        .spark       (spark),
        .fault_dwell (fault_dwell)
`ifdef HWAG_COIL_GUARD_STATS_EN
        ,
        .spark_cnt   (spark_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            bit r;
            bit tmo;
            int off_min;
            r       = coil_req[c];
            tmo     = 1'b0;
            off_min = (min_off == 0) ? 1 : int'(min_off);
            if (rst) begin
                m_chg[c]   = 0;
                m_len[c]   = 0;
                m_hold[c]  = 0;
                m_h[c]     = 0;
                m_wait[c]  = 0;
                m_spark[c] = 0;
                m_fault[c] = 0;
                m_stat[c]  = 0;
            end else begin
                m_stat[c]  = (m_stat[c] + (m_spark[c] ? 1 : 0)) % 65536;
                m_spark[c] = 0;
                if (!ena) begin
                    m_chg[c]  = 0;
                    m_hold[c] = 0;
                    m_wait[c] = 0;
                end else if (m_chg[c]) begin
                    m_len[c]++;
                    if (!r) begin
                        m_chg[c]   = 0;
                        m_spark[c] = 1;
                        m_hold[c]  = 1;
                        m_h[c]     = 0;
                    end else if (max_dwell != 0 && m_len[c] == int'(max_dwell)) begin
                        m_chg[c]   = 0;
                        m_spark[c] = 1;
                        m_wait[c]  = 1;
                        tmo        = 1;
                    end
                end else if (m_hold[c]) begin
                    m_h[c]++;
                    if (m_h[c] >= off_min) begin
                        m_hold[c] = 0;
                        m_wait[c] = r;
                    end
                end else if (m_wait[c]) begin
                    if (!r) m_wait[c] = 0;
                end else if (r) begin
                    m_chg[c] = 1;
                    m_len[c] = 0;
                end
                if (tmo) m_fault[c] = 1;
                else if (fault_clr) m_fault[c] = 0;
            end
        end
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            logic [CH-1:0] e_coil;
            logic [CH-1:0] e_spark;
            logic [CH-1:0] e_fault;
            @(posedge clk);
            model_step();
            #1;
            for (int c = 0; c < CH; c++) begin
                e_coil[c]  = m_chg[c];
                e_spark[c] = m_spark[c];
                e_fault[c] = m_fault[c];
            end
            chk("coil_out", coil_out, e_coil);
            chk("spark", spark, e_spark);
            chk("fault_dwell", fault_dwell, e_fault);
`ifdef HWAG_COIL_GUARD_STATS_EN
            for (int c = 0; c < CH; c++)
                chk("spark_cnt", spark_cnt[16*c +: 16], m_stat[c]);
`endif
            if (coil_out[0]) hi0++;
            if (spark[0]) sp0++;
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; coil_req = '0; fault_clr = 1'b0;
        max_dwell = 24'd100; min_off = 24'd20;
        cyc(3);
        chk("reset_coil", coil_out, 0);
        chk("reset_fault", fault_dwell, 0);
        rst = 1'b0; ena = 1'b1;
        cyc(2);

        // normal 50-cycle dwell
        hi0 = 0; sp0 = 0;
        coil_req = 2'b01; cyc(50);
        coil_req = 2'b00; cyc(60);
        chk("dwell50_high", hi0, 50);
        chk("dwell50_spark", sp0, 1);
        chk("dwell50_fault", fault_dwell, 0);

        // overdwell
        hi0 = 0; sp0 = 0;
        coil_req = 2'b01; cyc(300);
        chk("over_high", hi0, 100);
        chk("over_spark", sp0, 1);
        chk("over_fault", fault_dwell[0], 1);
        coil_req = 2'b00; cyc(5);
        chk("over_stay_low", hi0, 100);
        fault_clr = 1'b1; cyc(1);
        fault_clr = 1'b0; cyc(1);
        chk("fault_cleared", fault_dwell[0], 0);

        // re-request inside min_off
        hi0 = 0; sp0 = 0;
        coil_req = 2'b01; cyc(30);
        coil_req = 2'b00; cyc(5);
        coil_req = 2'b01; cyc(40);
        coil_req = 2'b00; cyc(5);
        chk("reissue_high", hi0, 30);
        chk("reissue_spark", sp0, 1);
        hi0 = 0;
        coil_req = 2'b01; cyc(10);
        chk("next_req_ok", hi0, 10);
        coil_req = 2'b00; cyc(30);

        // timeout disabled, long dwell
        hi0 = 0;
        max_dwell = 24'd0;
        coil_req = 2'b01; cyc(10000);
        chk("nolimit_high", hi0, 10000);
        chk("nolimit_fault", fault_dwell, 0);
        coil_req = 2'b00; cyc(30);
        max_dwell = 24'd100;
        hi0 = 0;
        coil_req = 2'b01; cyc(99);
        coil_req = 2'b00; cyc(30);
        chk("rel99_high", hi0, 99);
        hi0 = 0;
        coil_req = 2'b01; cyc(100);
        coil_req = 2'b00; cyc(30);
        chk("rel_at_limit_high", hi0, 100);
        chk("rel_at_limit_fault", fault_dwell, 0);

        // ena and rst mid-charge on ch1 with ch0 charging
        max_dwell = 24'd10;
        coil_req = 2'b10; cyc(15);
        chk("ch1_fault", fault_dwell, 2'b10);
        coil_req = 2'b00; cyc(25);
        max_dwell = 24'd100;
        coil_req = 2'b11; cyc(20);
        ena = 1'b0; cyc(1);
        chk("ena_off_coil", coil_out, 0);
        chk("ena_off_spark", spark, 0);
        chk("ena_off_fault", fault_dwell, 2'b10);
        ena = 1'b1; cyc(10);
        rst = 1'b1; cyc(1);
        chk("rst_coil", coil_out, 0);
        chk("rst_spark", spark, 0);
        chk("rst_fault", fault_dwell, 0);
        rst = 1'b0; coil_req = 2'b00; min_off = 24'd2;
        cyc(3);
        for (int p = 0; p < 3; p++) begin
            coil_req = 2'b01; cyc(5);
            coil_req = 2'b00; cyc(6);
        end
`ifdef HWAG_COIL_GUARD_STATS_EN
        chk("stats_three", spark_cnt[15:0], 3);
`endif

        // randomized traffic with live limit changes
        max_dwell = 24'd20; min_off = 24'd4;
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(11) == 0) coil_req[c] = ~coil_req[c];
            if ($urandom_range(49) == 0)
                max_dwell = ($urandom_range(7) == 0) ? 24'd0 : 24'($urandom_range(40, 1));
            if ($urandom_range(49) == 0)
                min_off = 24'($urandom_range(12));
            ena       = ($urandom_range(99) != 0);
            fault_clr = ($urandom_range(59) == 0);
            rst       = ($urandom_range(999) == 0);
            cyc(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
